// File: rtl/tlc549_adc_if_pkg.sv
// Shared types and helpers for the TLC549 serial ADC interface.
package tlc549_adc_if_pkg;

    // Frame sequencer states: CS_n high conversion wait, CS_n setup, clocked shift.
    typedef enum logic [1:0] {
        StWait  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2
    } adc_state_e;

    // Largest of three counts, used to size the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tlc549_adc_if_sync2.sv
// Generic two-flop bit synchroniser, reset to 0.
module tlc549_adc_if_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; only q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tlc549_adc_if.sv
// Serial master for the TLC549 8-bit ADC: runs back-to-back conversion frames, drives
// CS_n and the I/O clock from flops, and publishes each sample with a one-cycle strobe.
module tlc549_adc_if
    import tlc549_adc_if_pkg::*;
#(
    parameter int unsigned CLK_HALF     = 12,
    parameter int unsigned SETUP_CYCLES = 36,
    parameter int unsigned CONV_CYCLES  = 456,
    parameter logic [7:0]  RESET_VALUE  = 8'h80
) (
    input  logic       clk24,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       adc_data_in,
    output logic [7:0] adc_data,
    output logic       adc_valid,
    output logic       adc_clk,
    output logic       adc_cs_n
);

    localparam int unsigned CNT_W = $clog2(max3(CONV_CYCLES, SETUP_CYCLES, 2 * CLK_HALF));

    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_HALF - 1);

    adc_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             dummy;
    logic [7:0]       shreg;
    logic             sdi;

    tlc549_adc_if_sync2 u_sync2 (
        .clk   (clk24),
        .rst_n (reset_n),
        .d     (adc_data_in),
        .q     (sdi)
    );

    // Frame sequencer; every pin-facing output is a flop so adc_clk/adc_cs_n cannot glitch.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StWait;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            dummy     <= 1'b1;
            shreg     <= 8'h00;
            adc_data  <= RESET_VALUE;
            adc_valid <= 1'b0;
            adc_clk   <= 1'b0;
            adc_cs_n  <= 1'b1;
        end else begin
            adc_valid <= 1'b0;
            unique case (state)
                StWait: begin
                    adc_cs_n <= 1'b1;
                    adc_clk  <= 1'b0;
                    // Counter saturates so a late enable starts the next frame at once.
                    if (cnt != CONV_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (enable) begin
                        state    <= StSetup;
                        cnt      <= '0;
                        adc_cs_n <= 1'b0;
                    end
                end
                StSetup: begin
                    if (cnt != SETUP_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state   <= StShift;
                        cnt     <= '0;
                        bit_idx <= 3'd7;
                    end
                end
                StShift: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!adc_clk) begin
                            adc_clk <= 1'b1;
                        end else begin
                            // End of a high half: sample the bit and drop the clock.
                            adc_clk <= 1'b0;
                            shreg   <= {shreg[6:0], sdi};
                            if (bit_idx == 3'd0) begin
                                adc_cs_n <= 1'b1;
                                state    <= StWait;
                                dummy    <= 1'b0;
                                // First frame after reset carries a stale conversion.
                                if (!dummy) begin
                                    adc_data  <= {shreg[6:0], sdi};
                                    adc_valid <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx - 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= StWait;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
